// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction-fetch request controller with a one-entry output slot
// Optional perf counters are enabled by defining FETCH_PERF_EN.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_adel,
  input  logic        fs_ready,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_EXC
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        stale;

  logic        redir;
  logic [31:0] redir_pc;
  logic        slot_free;
  logic        pc_misaligned;
  logic        adel_fill;
  logic        resp_fill;

  assign redir         = flush | br_taken;
  assign redir_pc      = flush ? flush_pc : br_target;
  assign slot_free     = !fs_valid | fs_ready;
  assign pc_misaligned = (pc[1:0] != 2'b00);
  assign adel_fill     = (state == S_IDLE) & !redir & pc_misaligned & slot_free;
  assign resp_fill     = (state == S_WAIT) & inst_data_ok & !redir;

  // Request outputs come straight from registered state, never from cache inputs.
  assign inst_req  = (state == S_REQ);
  assign inst_addr = req_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      stale    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!redir && slot_free) begin
            if (pc_misaligned) begin
              state <= S_EXC;
            end else begin
              req_addr <= pc;
              stale    <= 1'b0;
              state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (redir) stale <= 1'b1;
          if (inst_addr_ok) state <= (stale | redir) ? S_DROP : S_WAIT;
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            if (!redir) pc <= req_addr + 32'd4;
            state <= S_IDLE;
          end else if (redir) begin
            state <= S_DROP;
          end
        end
        S_DROP: begin
          if (inst_data_ok) state <= S_IDLE;
        end
        S_EXC: begin
          if (redir) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Redirect target overrides the sequential pc+4 update above.
      if (redir) pc <= redir_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fs_pc    <= 32'd0;
      fs_inst  <= 32'd0;
      fs_adel  <= 1'b0;
    end else if (flush) begin
      fs_valid <= 1'b0;
    end else if (resp_fill) begin
      fs_valid <= 1'b1;
      fs_pc    <= req_addr;
      fs_inst  <= inst_rdata;
      fs_adel  <= 1'b0;
    end else if (adel_fill) begin
      fs_valid <= 1'b1;
      fs_pc    <= pc;
      fs_inst  <= 32'd0;
      fs_adel  <= 1'b1;
    end else if (fs_valid && fs_ready) begin
      fs_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  logic resp_drop;
  assign resp_drop = inst_data_ok & ((state == S_DROP) | ((state == S_WAIT) & redir));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= 32'd0;
      perf_drop_cnt  <= 32'd0;
    end else begin
      if (resp_fill) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (resp_drop) perf_drop_cnt  <= perf_drop_cnt + 32'd1;
    end
  end
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_drop_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - directed self-checking bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] flush_pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_adel;
  logic        fs_ready;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;

  int checks = 0;
  int failures = 0;

  inst_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .fs_valid       (fs_valid),
    .fs_pc          (fs_pc),
    .fs_inst        (fs_inst),
    .fs_adel        (fs_adel),
    .fs_ready       (fs_ready),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 0; flush_pc = 0; br_taken = 0; br_target = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0; fs_ready = 1;
    tick(); tick();
    checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%h exp=0", inst_req); end
    checks++; if (inst_addr !== 32'hbfc00000) begin failures++; $display("FAIL rst_addr got=%h exp=bfc00000", inst_addr); end
    checks++; if ({fs_valid, fs_adel} !== 2'b00) begin failures++; $display("FAIL rst_slot_flags got=%b exp=00", {fs_valid, fs_adel}); end
    checks++; if ({fs_pc, fs_inst} !== 64'd0) begin failures++; $display("FAIL rst_slot_data got=%h exp=0", {fs_pc, fs_inst}); end
    checks++; if ({perf_fetch_cnt, perf_drop_cnt} !== 64'd0) begin failures++; $display("FAIL rst_perf got=%h exp=0", {perf_fetch_cnt, perf_drop_cnt}); end
  endtask

  // Ends with the controller in REQ for 0xbfc00004.
  task automatic test_first_fetch();
    reset = 1'b0;
    checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL ff_idle_req got=%h exp=0", inst_req); end
    tick();
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00000) begin failures++; $display("FAIL ff_req got=%h/%h exp=1/bfc00000", inst_req, inst_addr); end
    tick();
    inst_addr_ok = 1; tick(); inst_addr_ok = 0;
    checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL ff_wait_req got=%h exp=0", inst_req); end
    tick();
    inst_data_ok = 1; inst_rdata = 32'h24010001; tick(); inst_data_ok = 0;
    checks++; if (fs_valid !== 1'b1 || fs_pc !== 32'hbfc00000 || fs_inst !== 32'h24010001 || fs_adel !== 1'b0)
      begin failures++; $display("FAIL ff_slot got=%h/%h/%h/%h exp=1/bfc00000/24010001/0", fs_valid, fs_pc, fs_inst, fs_adel); end
    tick();
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00004) begin failures++; $display("FAIL ff_next_req got=%h/%h exp=1/bfc00004", inst_req, inst_addr); end
    checks++; if (fs_valid !== 1'b0) begin failures++; $display("FAIL ff_drained got=%h exp=0", fs_valid); end
  endtask

  // Ends in REQ for 0xbfc00008.
  task automatic test_backpressure();
    fs_ready = 0;
    inst_addr_ok = 1; tick(); inst_addr_ok = 0;
    inst_data_ok = 1; inst_rdata = 32'h24020002; tick(); inst_data_ok = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL bp_no_req[%0d] got=%h exp=0", i, inst_req); end
      checks++; if (fs_valid !== 1'b1 || fs_pc !== 32'hbfc00004 || fs_inst !== 32'h24020002)
        begin failures++; $display("FAIL bp_hold[%0d] got=%h/%h/%h exp=1/bfc00004/24020002", i, fs_valid, fs_pc, fs_inst); end
    end
    fs_ready = 1; tick();
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00008) begin failures++; $display("FAIL bp_resume got=%h/%h exp=1/bfc00008", inst_req, inst_addr); end
    checks++; if (fs_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%h exp=0", fs_valid); end
  endtask

  // Ends in REQ for 0xbfc00380.
  task automatic test_flush_wait();
    inst_addr_ok = 1; tick(); inst_addr_ok = 0;
    flush = 1; flush_pc = 32'hbfc00380; tick(); flush = 0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (fs_valid !== 1'b0 || inst_req !== 1'b0) begin failures++; $display("FAIL fw_quiet[%0d] got=%h/%h exp=0/0", i, fs_valid, inst_req); end
      tick();
    end
    inst_data_ok = 1; inst_rdata = 32'hdeadbeef; tick(); inst_data_ok = 0;
    checks++; if (fs_valid !== 1'b0) begin failures++; $display("FAIL fw_dropped got=%h exp=0", fs_valid); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_drop_cnt !== 32'd1) begin failures++; $display("FAIL fw_drop_cnt got=%0d exp=1", perf_drop_cnt); end
`endif
    tick();
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00380) begin failures++; $display("FAIL fw_next got=%h/%h exp=1/bfc00380", inst_req, inst_addr); end
  endtask

  // Ends in REQ for 0xbfc00100.
  task automatic test_branch_req();
    br_taken = 1; br_target = 32'hbfc00100; tick(); br_taken = 0;
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00380) begin failures++; $display("FAIL br_hold got=%h/%h exp=1/bfc00380", inst_req, inst_addr); end
    tick();
    inst_addr_ok = 1; tick(); inst_addr_ok = 0;
    checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL br_drop_req got=%h exp=0", inst_req); end
    tick();
    inst_data_ok = 1; inst_rdata = 32'h11111111; tick(); inst_data_ok = 0;
    checks++; if (fs_valid !== 1'b0) begin failures++; $display("FAIL br_dropped got=%h exp=0", fs_valid); end
    tick();
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00100) begin failures++; $display("FAIL br_next got=%h/%h exp=1/bfc00100", inst_req, inst_addr); end
  endtask

  // Ends in REQ for 0xbfc00380.
  task automatic test_adel();
    flush = 1; flush_pc = 32'hbfc00002; tick(); flush = 0;
    inst_addr_ok = 1; tick(); inst_addr_ok = 0;
    tick();
    inst_data_ok = 1; tick(); inst_data_ok = 0;
    tick();
    checks++; if (fs_valid !== 1'b1 || fs_adel !== 1'b1 || fs_inst !== 32'd0 || fs_pc !== 32'hbfc00002)
      begin failures++; $display("FAIL adel_slot got=%h/%h/%h/%h exp=1/1/0/bfc00002", fs_valid, fs_adel, fs_inst, fs_pc); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL adel_no_req[%0d] got=%h exp=0", i, inst_req); end
      tick();
    end
`ifdef FETCH_PERF_EN
    checks++; if (perf_fetch_cnt !== 32'd2 || perf_drop_cnt !== 32'd3)
      begin failures++; $display("FAIL adel_perf got=%0d/%0d exp=2/3", perf_fetch_cnt, perf_drop_cnt); end
`endif
    flush = 1; flush_pc = 32'hbfc00380; tick(); flush = 0;
    tick();
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00380) begin failures++; $display("FAIL adel_exit got=%h/%h exp=1/bfc00380", inst_req, inst_addr); end
  endtask

  // Ends in REQ for 0xbfc00380 with fs_ready low.
  task automatic test_flush_and_branch();
    fs_ready = 0;
    inst_addr_ok = 1; tick(); inst_addr_ok = 0;
    inst_data_ok = 1; inst_rdata = 32'h3c1d0000; tick(); inst_data_ok = 0;
    checks++; if (fs_valid !== 1'b1 || fs_inst !== 32'h3c1d0000) begin failures++; $display("FAIL fb_full got=%h/%h exp=1/3c1d0000", fs_valid, fs_inst); end
    flush = 1; flush_pc = 32'hbfc00380; br_taken = 1; br_target = 32'hbfc00100; tick();
    flush = 0; br_taken = 0;
    checks++; if (fs_valid !== 1'b0) begin failures++; $display("FAIL fb_cleared got=%h exp=0", fs_valid); end
    tick();
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00380) begin failures++; $display("FAIL fb_next got=%h/%h exp=1/bfc00380", inst_req, inst_addr); end
  endtask

  // Ends in REQ for 0x00000000.
  task automatic test_wrap();
    fs_ready = 1;
    flush = 1; flush_pc = 32'hfffffffc; tick(); flush = 0;
    inst_addr_ok = 1; tick(); inst_addr_ok = 0;
    inst_data_ok = 1; tick(); inst_data_ok = 0;
    tick();
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hfffffffc) begin failures++; $display("FAIL wr_req got=%h/%h exp=1/fffffffc", inst_req, inst_addr); end
    inst_addr_ok = 1; tick(); inst_addr_ok = 0;
    inst_data_ok = 1; inst_rdata = 32'h00000001; tick(); inst_data_ok = 0;
    checks++; if (fs_valid !== 1'b1 || fs_pc !== 32'hfffffffc) begin failures++; $display("FAIL wr_slot got=%h/%h exp=1/fffffffc", fs_valid, fs_pc); end
    tick();
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h00000000) begin failures++; $display("FAIL wr_next got=%h/%h exp=1/00000000", inst_req, inst_addr); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_fetch_cnt !== 32'd4 || perf_drop_cnt !== 32'd4)
      begin failures++; $display("FAIL wr_perf got=%0d/%0d exp=4/4", perf_fetch_cnt, perf_drop_cnt); end
`endif
  endtask

  task automatic test_mid_reset();
    reset = 1; #1;
    checks++; if (inst_req !== 1'b0 || inst_addr !== 32'hbfc00000) begin failures++; $display("FAIL mr_req got=%h/%h exp=0/bfc00000", inst_req, inst_addr); end
    checks++; if (fs_valid !== 1'b0 || perf_fetch_cnt !== 32'd0) begin failures++; $display("FAIL mr_state got=%h/%0d exp=0/0", fs_valid, perf_fetch_cnt); end
    tick(); reset = 0;
    tick();
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00000) begin failures++; $display("FAIL mr_restart got=%h/%h exp=1/bfc00000", inst_req, inst_addr); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_flush_wait();
    test_branch_req();
    test_adel();
    test_flush_and_branch();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-fetch request controller sitting between the PC-generation logic and the instruction cache's SRAM-like port. It owns the fetch PC and issues one request at a time with an `inst_req`/`inst_addr_ok`/`inst_data_ok` handshake. Responses made stale by a redirect are cancelled, and each fetched instruction (or an address-error marker) is delivered through a one-entry output slot with a valid/ready handshake toward the IF/ID boundary.

## Interface
- `RESET_PC`, default `32'hbfc00000`: fetch PC after reset.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: exception/ERET redirect. Highest priority. Also clears the output slot.
- `flush_pc` in 32: target PC for `flush`.
- `br_taken` in 1: branch redirect. Does not clear the output slot.
- `br_target` in 32: target PC for `br_taken`.
- `inst_req` out 1: request valid toward the cache.
- `inst_addr` out 32: request address. Held stable while `inst_req`=1.
- `inst_addr_ok` in 1: request accepted.
- `inst_data_ok` in 1: response valid.
- `inst_rdata` in 32: response instruction.
- `fs_valid` out 1: output slot holds an entry.
- `fs_pc` out 32: PC of the slot entry.
- `fs_inst` out 32: instruction; 0 when `fs_adel`=1.
- `fs_adel` out 1: slot entry is a misaligned-fetch (AdEL) marker.
- `fs_ready` in 1: downstream accepts the slot entry this cycle.
- `perf_fetch_cnt` out 32: delivered-instruction count.
- `perf_drop_cnt` out 32: discarded-response count.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `req_addr`: latched request address.
  - `stale`: in-flight request belongs to the wrong path.
  - Output slot: `fs_valid`/`fs_pc`/`fs_inst`/`fs_adel`.
  - `state`.
- Redirect: `redir = flush | br_taken`; `redir_pc = flush ? flush_pc : br_target`.
  - Any redirect writes `pc <= redir_pc` in any state.
  - Redirect has priority over every `pc` update below.
- Branch contract: `br_taken` is only asserted once the delay-slot instruction is already in the slot or consumed. Any in-flight fetch at that time is therefore wrong-path.
- Slot free condition: `slot_free = !fs_valid | fs_ready`.
  - Slot drains on `fs_valid & fs_ready`.
  - `flush` clears `fs_valid` next cycle, overriding any same-cycle fill.
- States:
  - **IDLE**
    - `redir`: stay IDLE.
    - else if `pc[1:0]!=0` and `slot_free`: fill slot with {`pc`, inst=0, adel=1}, go to EXC.
    - else if `slot_free`: `req_addr <= pc`, `stale <= 0`, go to REQ.
  - **REQ**: `inst_req`=1, `inst_addr=req_addr`.
    - `redir` sets `stale`.
    - On `inst_addr_ok`: go to DROP if `stale|redir`, else WAIT.
  - **WAIT**
    - `inst_data_ok & !redir`: fill slot with {`req_addr`, `inst_rdata`, adel=0}, `pc <= req_addr+4`, go to IDLE.
    - `inst_data_ok & redir`: discard the response, go to IDLE.
    - `redir` without `inst_data_ok`: go to DROP.
  - **DROP**: on `inst_data_ok`, discard the response and go to IDLE.
  - **EXC**: no requests issued; on `redir`, go to IDLE.
- One request outstanding at most. The slot is always empty when a response arrives, so no overflow is possible.
- `pc+4` wraps modulo 2^32.

## Timing
- Reset values:
  - `state`=IDLE, `pc`=`RESET_PC`.
  - `inst_req`=0, `inst_addr`=`RESET_PC`.
  - `fs_valid`=0, `fs_pc`=0, `fs_inst`=0, `fs_adel`=0.
  - `stale`=0, both perf counters 0.
- `inst_req` and `inst_addr` are decoded from registered state; no combinational path from cache inputs.
- Request latency: first cycle after reset deassertion is IDLE; `inst_req`=1 from the second cycle.
- Delivery latency: `inst_data_ok` in cycle k gives `fs_valid`=1 in cycle k+1.
- Throughput: ≥3 cycles per instruction (IDLE→REQ→WAIT).
- Cache contract: `inst_data_ok` never arrives in the same cycle as its own `inst_addr_ok`.
- Reset asserted mid-transaction: all state clears immediately. A later orphan `inst_data_ok` is only possible if the cache is not reset together with this block; it is excluded by the system reset contract.
- `flush` and `br_taken` in the same cycle: `flush_pc` wins and the slot is cleared.

## Configuration
- `FETCH_PERF_EN` defined:
  - `perf_fetch_cnt` increments on every adel=0 slot fill.
  - `perf_drop_cnt` increments on every discarded response (DROP or WAIT+redir).
  - Both wrap at 2^32.
- `FETCH_PERF_EN` undefined: both ports tied to 0, no counter flops.

## Test plan
- Reset release, cache `inst_addr_ok` after 1 cycle, `inst_data_ok` 2 cycles later with `rdata`=0x24010001, `fs_ready`=1 → `inst_addr`=0xbfc00000, then `fs_pc`=0xbfc00000 and `fs_inst`=0x24010001; the next request has address 0xbfc00004.
- `fs_ready`=0 with slot full → no new `inst_req`. Raise `fs_ready` → `inst_req` reasserts within 2 cycles, with the slot entry unchanged until accepted.
- `flush`=1, `flush_pc`=0xbfc00380 while in WAIT, then `inst_data_ok` 3 cycles later → response dropped (`perf_drop_cnt`=1 with the macro), next `inst_addr`=0xbfc00380, `fs_valid`=0 throughout.
- `br_taken`=1, `br_target`=0xbfc00100 during REQ, before `inst_addr_ok` → `inst_addr` stays at the old value until accepted, the response is dropped, and the next request is 0xbfc00100.
- `flush_pc`=0xbfc00002 → `fs_valid`=1, `fs_adel`=1, `fs_inst`=0, `fs_pc`=0xbfc00002, no `inst_req` until the next `flush` to 0xbfc00380.
- Simultaneous `flush` (0xbfc00380) and `br_taken` (0xbfc00100) with the slot full → slot cleared, next request 0xbfc00380.
